platform_collision: RTL and testbench
=====================================

Name: platform_collision

Overview:
- Upstream of the platform scroller. Once per frame, scans all 90 platform slots serially, one per clock, against the doodle's feet.
- Produces the registered `move_collision` flag that the scroller samples on its end-of-frame tick.
- Also reports which platform was hit and, optionally, a landing-correction Y.
- Sits between the doodle physics block and the platform scroller.

Parameters:
- FPS, 60, frame rate; shared with the scroller.
- CLK, 50000000, clock frequency in Hz; `CLK/FPS` must exceed `N_PLAT+4`.
- N_PLAT, 90, number of platform slots scanned.
- PLAT_W, 100, platform width in pixels.
- DOODLE_W, 80, doodle sprite width in pixels.
- DOODLE_H, 80, doodle sprite height in pixels.
- FOOT_TOL, 12, vertical tolerance in pixels below the platform top that still counts as a landing.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- fps_counter  in  $clog2(CLK/FPS)+1  frame-phase counter shared with the scroller
- platforms  in  N_PLAT*2*11  signed {y,x} per slot, same packing as the scroller output
- platform_activation  in  N_PLAT  slot-active mask
- doodle_x  in  11  doodle left edge
- doodle_y  in  10  doodle top edge
- doodle_falling  in  1  high while doodle vertical velocity is downward
- move_collision  out  1  landing detected in the last completed scan
- hit_index  out  7  lowest slot index hit in the last scan; 0 if none
- scan_done  out  1  one-cycle pulse when a scan completes
- snap_y  out  10  corrected doodle_y for the landing (see optional feature)

Behaviour:
- Reset: every output is 0, FSM is IDLE, index counter is 0. Reset is asynchronous and active-low.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on the cycle where `fps_counter == 0`, i.e. the first tick after the scroller update.
  - On entry, latch `doodle_x`, `doodle_y` and `doodle_falling` into shadow registers.
  - Clear the internal hit flag and index counter.
- SCAN, one slot per cycle at index `k`:
  - Slot hits if all of the following hold:
    - `platform_activation[k]` is set;
    - the latched falling flag is set;
    - `feet = doodle_y + DOODLE_H - 1` satisfies `p_y <= feet <= p_y + FOOT_TOL`;
    - `doodle_x + DOODLE_W - 1 >= p_x` and `doodle_x <= p_x + PLAT_W - 1`.
  - All comparisons are 12-bit signed. `doodle_x` and `doodle_y` are zero-extended; `p_y` and `p_x` are sign-extended from 11 bits, so negative (off-screen) `p_y` compares correctly.
  - First hit wins: record `k` and raise the internal flag. Later hits in the same scan are ignored.
  - When `k == N_PLAT-1`, go to DONE.
- DONE (one cycle):
  - Copy the internal flag to `move_collision` and the recorded index to `hit_index` (0 if no hit).
  - Pulse `scan_done` high for exactly this cycle, then go to IDLE.
- Latency: outputs update `N_PLAT+1` cycles after the `fps_counter == 0` tick. They are stable long before the scroller samples on `&fps_counter`.
- Outputs hold between scans. `move_collision` is therefore level-valid for the whole next frame.
- `fps_counter == 0` while in SCAN or DONE is ignored; there is no restart.
- Changes to inputs during SCAN: doodle inputs use the latched shadows. `platforms` and `platform_activation` are read live, because the scroller only changes them on `&fps_counter`.
- Reset asserted mid-scan: abort immediately and return all outputs to reset values. The first scan after release starts at the next `fps_counter == 0`.
- Boundary: `feet == p_y` hits and `feet == p_y + FOOT_TOL` hits; `+1` beyond that misses. An x-overlap of exactly one pixel at either edge hits.

Optional Feature:
- Macro: COLLISION_SNAP_EN.
- Defined: at DONE with a hit, `snap_y = p_y[hit] - DOODLE_H`, truncated to 10 bits, using the `p_y` latched at hit time. `snap_y` holds until the next DONE with a hit; DONE without a hit leaves it unchanged.
- Not defined: `snap_y` is constant 0 and no latch register is built.

Test Plan:
- Reset mid-SCAN at k=40, with a hit already recorded at k=3 → all outputs 0 immediately; after release, the next frame-start scan reports correctly.
- Doodle (x=350, y=200) falling; slot 7 active at (y=279, x=342) → `move_collision`=1, `hit_index`=7, `scan_done` pulse exactly `N_PLAT+1` cycles after `fps_counter==0`; with COLLISION_SNAP_EN, `snap_y`=199.
- Same geometry with `doodle_falling`=0 → `move_collision`=0, `hit_index`=0, `scan_done` still pulses once.
- Slots 4 and 9 both overlapping → `hit_index`=4.
- Feet edge cases: p_y=279 with feet=291 hits; p_y=279 with feet=292 misses; x overlap of exactly one pixel (`doodle_x`=441, p_x=342) hits, `doodle_x`=442 misses.
- Slot inactive (activation bit 0) with perfect overlap → no hit; negative p_y=-30 with feet=-20 is never true, so no hit and no spurious sign wrap.

Source files
------------

// File: rtl/platform_collision.sv
// platform_collision
//   Once per frame, walks the N_PLAT platform slots one per clock and checks
//   each against the doodle's feet. The result (landing flag, lowest hit slot,
//   optional landing-corrected Y) is registered and held for the whole next
//   frame, so the scroller can sample it on its end-of-frame tick.
//
//   Optional feature macro: COLLISION_SNAP_EN
//     defined   : snap_y = p_y[hit] - DOODLE_H on each scan that lands
//     undefined : snap_y tied to 0, no p_y capture register
//
// Ports
//   clk                  system clock
//   rst                  asynchronous active-low reset
//   fps_counter          frame-phase counter; a scan starts when it reads 0
//   platforms            N_PLAT x {y[10:0], x[10:0]} signed, slot k at [22k +: 22]
//   platform_activation  per-slot active mask
//   doodle_x / doodle_y  doodle left / top edge (unsigned)
//   doodle_falling       doodle moving downward
//   move_collision       landing found in last completed scan
//   hit_index            lowest slot hit in last scan, 0 if none
//   scan_done            one-cycle pulse when results update
//   snap_y               corrected doodle_y for the landing
module platform_collision #(
  parameter int FPS      = 60,
  parameter int CLK      = 50000000,
  parameter int N_PLAT   = 90,
  parameter int PLAT_W   = 100,
  parameter int DOODLE_W = 80,
  parameter int DOODLE_H = 80,
  parameter int FOOT_TOL = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(CLK/FPS):0]  fps_counter,
  input  logic [N_PLAT*2*11-1:0]    platforms,
  input  logic [N_PLAT-1:0]         platform_activation,
  input  logic [10:0]               doodle_x,
  input  logic [9:0]                doodle_y,
  input  logic                      doodle_falling,
  output logic                      move_collision,
  output logic [6:0]                hit_index,
  output logic                      scan_done,
  output logic [9:0]                snap_y
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic [N_PLAT-1:0][21:0] plat;
  assign plat = platforms;

  logic [6:0]  k;
  logic [10:0] sh_x;
  logic [9:0]  sh_y;
  logic        sh_fall;
  logic        hit_flag;
  logic [6:0]  hit_idx_q;

  logic              last;
  logic              hit_now;
  logic [21:0]       slot;
  logic signed [11:0] py, px, py_lo_tol, px_right, feet, d_left, d_right;

  assign last = (k == 7'(N_PLAT - 1));

  // Slot geometry: p_y/p_x sign-extended, doodle coords zero-extended, so
  // off-screen (negative) platforms compare correctly in 12-bit signed.
  always_comb begin
    slot      = plat[k];
    py        = {slot[21], slot[21:11]};
    px        = {slot[10], slot[10:0]};
    py_lo_tol = py + 12'(FOOT_TOL);
    px_right  = px + 12'(PLAT_W - 1);
    feet      = $signed({2'b00, sh_y} + 12'(DOODLE_H - 1));
    d_left    = $signed({1'b0, sh_x});
    d_right   = $signed({1'b0, sh_x} + 12'(DOODLE_W - 1));
    hit_now   = (state == SCAN) && platform_activation[k] && sh_fall &&
                (py <= feet) && (feet <= py_lo_tol) &&
                (d_right >= px) && (d_left <= px_right);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fps_counter == '0) state_nxt = SCAN;
      SCAN:    if (last)              state_nxt = DONE;
      DONE:                           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // ---------------- scan datapath ----------------
  // Results are written on the edge that leaves the last slot so the final
  // slot's hit is folded in; they are visible during DONE together with the
  // scan_done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k              <= '0;
      sh_x           <= '0;
      sh_y           <= '0;
      sh_fall        <= 1'b0;
      hit_flag       <= 1'b0;
      hit_idx_q      <= '0;
      move_collision <= 1'b0;
      hit_index      <= '0;
      scan_done      <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: if (fps_counter == '0) begin
          sh_x      <= doodle_x;
          sh_y      <= doodle_y;
          sh_fall   <= doodle_falling;
          k         <= '0;
          hit_flag  <= 1'b0;
          hit_idx_q <= '0;
        end
        SCAN: begin
          // first hit wins
          if (hit_now && !hit_flag) begin
            hit_flag  <= 1'b1;
            hit_idx_q <= k;
          end
          if (last) begin
            move_collision <= hit_flag | hit_now;
            hit_index      <= hit_flag ? hit_idx_q : (hit_now ? k : 7'd0);
            scan_done      <= 1'b1;
          end else begin
            k <= k + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COLLISION_SNAP_EN
  // p_y of the first hit slot, captured at hit time
  logic [10:0] hit_py_q;
  logic [10:0] land_py;

  assign land_py = hit_flag ? hit_py_q : slot[21:11];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_py_q <= '0;
      snap_y   <= '0;
    end else if (state == SCAN) begin
      if (hit_now && !hit_flag) hit_py_q <= slot[21:11];
      if (last && (hit_flag || hit_now))
        snap_y <= 10'({land_py[10], land_py} - 12'(DOODLE_H));
    end
  end
`else
  assign snap_y = '0;
`endif

endmodule

// File: tb/tb_platform_collision.sv
module tb_platform_collision;
  localparam int N_PLAT = 90;
  localparam int FCW    = $clog2(50000000/60) + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [FCW-1:0]         fps_counter = '1;
  logic [N_PLAT*22-1:0]   platforms = '0;
  logic [N_PLAT-1:0]      platform_activation = '0;
  logic [10:0]            doodle_x = '0;
  logic [9:0]             doodle_y = '0;
  logic                   doodle_falling = 1'b0;
  logic                   move_collision;
  logic [6:0]             hit_index;
  logic                   scan_done;
  logic [9:0]             snap_y;

  platform_collision dut (
    .clk(clk), .rst(rst), .fps_counter(fps_counter), .platforms(platforms),
    .platform_activation(platform_activation), .doodle_x(doodle_x),
    .doodle_y(doodle_y), .doodle_falling(doodle_falling),
    .move_collision(move_collision), .hit_index(hit_index),
    .scan_done(scan_done), .snap_y(snap_y)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       mc;
    logic [6:0] idx;
    logic [9:0] snap;
    longint     start;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [9:0] snap_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every scan_done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst && scan_done) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_scan_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("move_collision", 32'(move_collision), 32'(e.mc));
        chk("hit_index",      32'(hit_index),      32'(e.idx));
        chk("snap_y",         32'(snap_y),         32'(e.snap));
        chk("latency",        32'(cyc - e.start),  32'(N_PLAT + 1));
      end
    end
  end

  task automatic clear_all();
    platforms = '0;
    platform_activation = '0;
  endtask

  task automatic set_slot(input int k, input int y, input int x);
    logic [10:0] yy, xx;
    yy = y[10:0];
    xx = x[10:0];
    platforms[k*22 +: 22] = {yy, xx};
    platform_activation[k] = 1'b1;
  endtask

  task automatic set_doodle(input int x, input int y, input logic f);
    doodle_x = x[10:0];
    doodle_y = y[9:0];
    doodle_falling = f;
  endtask

  // start a scan and wait for the monitor to consume its expectation;
  // glitch re-asserts fps_counter==0 mid-scan, which must be ignored
  task automatic run_scan(input logic mc, input int idx, input int py, input logic glitch);
    exp_t e;
`ifdef COLLISION_SNAP_EN
    if (mc) snap_m = 10'(py - 80);
`endif
    @(negedge clk);
    fps_counter = '0;
    e.mc = mc; e.idx = idx[6:0]; e.snap = snap_m; e.start = cyc;
    sb.push_back(e);
    @(negedge clk);
    fps_counter = FCW'(7);
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      fps_counter = (glitch && i == 20) ? '0 : FCW'(7);
      @(negedge clk);
    end
    fps_counter = FCW'(7);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scan_timeout: got no scan_done expected one within 200 cycles");
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_mc",   32'(move_collision), 0);
    chk("reset_idx",  32'(hit_index),      0);
    chk("reset_done", 32'(scan_done),      0);
    chk("reset_snap", 32'(snap_y),         0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic landing, with an ignored mid-scan frame tick
    clear_all(); set_slot(7, 279, 342); set_doodle(350, 200, 1'b1);
    run_scan(1'b1, 7, 279, 1'b1);
    // not falling
    set_doodle(350, 200, 1'b0);
    run_scan(1'b0, 0, 0, 1'b0);
    // two overlapping slots: lowest wins
    clear_all(); set_slot(4, 279, 342); set_slot(9, 279, 342); set_doodle(350, 200, 1'b1);
    run_scan(1'b1, 4, 279, 1'b0);

    // reset mid-scan with a hit recorded at slot 3
    clear_all(); set_slot(3, 279, 342); set_doodle(350, 200, 1'b1);
    @(negedge clk); fps_counter = '0;
    @(negedge clk); fps_counter = FCW'(7);
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_mc",   32'(move_collision), 0);
    chk("midreset_idx",  32'(hit_index),      0);
    chk("midreset_done", 32'(scan_done),      0);
    chk("midreset_snap", 32'(snap_y),         0);
    snap_m = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_release_idle_mc", 32'(move_collision), 0);

    clear_all(); set_slot(7, 279, 342); set_doodle(350, 200, 1'b1);
    run_scan(1'b1, 7, 279, 1'b0);
    // feet at p_y+FOOT_TOL hits, one further misses
    set_doodle(350, 212, 1'b1); run_scan(1'b1, 7, 279, 1'b0);
    set_doodle(350, 213, 1'b1); run_scan(1'b0, 0, 0, 1'b0);
    // one-pixel x overlap at right edge of platform
    set_doodle(441, 200, 1'b1); run_scan(1'b1, 7, 279, 1'b0);
    set_doodle(442, 200, 1'b1); run_scan(1'b0, 0, 0, 1'b0);
    // one-pixel x overlap at left edge of platform (doodle right = 342)
    set_doodle(263, 200, 1'b1); run_scan(1'b1, 7, 279, 1'b0);
    set_doodle(262, 200, 1'b1); run_scan(1'b0, 0, 0, 1'b0);
    // inactive slot with perfect overlap
    platform_activation = '0; set_doodle(350, 200, 1'b1);
    run_scan(1'b0, 0, 0, 1'b0);
    // negative p_y never matches
    clear_all(); set_slot(7, -30, 342); set_doodle(350, 0, 1'b1);
    run_scan(1'b0, 0, 0, 1'b0);
    // first and last slot
    clear_all(); set_slot(0, 300, 342); set_doodle(350, 221, 1'b1);
    run_scan(1'b1, 0, 300, 1'b0);
    clear_all(); set_slot(89, 279, 342); set_doodle(350, 200, 1'b1);
    run_scan(1'b1, 89, 279, 1'b0);
    // results hold between scans
    repeat (5) @(negedge clk);
    chk("hold_mc",  32'(move_collision), 1);
    chk("hold_idx", 32'(hit_index),      89);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
